rainbow_fader: RTL and testbench



---
 rtl/rainbow_fader.sv | 84 ++++++++
 tb/tb_rainbow_fader.sv | 93 +++++++++
 2 files changed

// File: rtl/rainbow_fader.sv
// rainbow_fader: dithered six-colour rainbow LED sequencer; optional brightness via RAINBOW_FADER_BRIGHT_EN
module rainbow_fader #(
  parameter int TICKS_PER_SLOT  = 12000,
  parameter int STEPS           = 70,
  parameter int FRAMES_PER_STEP = 1,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
`ifdef RAINBOW_FADER_BRIGHT_EN
  input  logic [3:0] bright,
`endif
  output logic [2:0] led,
  output logic [2:0] seg_idx,
  output logic       frame_tick,
  output logic       seg_done,
  output logic       cycle_done
);
  localparam int TW = $clog2(TICKS_PER_SLOT);
  localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [2:0] POL = ACTIVE_LOW != 0 ? 3'b111 : 3'b000;
  // {R,B,G} active-high, index 0 (red) in the low bits
  localparam logic [17:0] COLORS = {3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};
  logic [TW-1:0] tick_q, tick_d;
  logic [7:0]    slot_q, slot_d, step_q, step_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [2:0]    seg_q, seg_d, fut, sel, led_d;
  logic          dir_q, dir_d;
  logic          tick_w, slot_w, frame_w, step_w, wrap, lit;
  always_comb begin
    tick_w  = tick_q == TW'(TICKS_PER_SLOT - 1);
    slot_w  = tick_w && slot_q == 8'(STEPS - 1);
    frame_w = slot_w && frame_q == FW'(FRAMES_PER_STEP - 1);
    step_w  = frame_w && step_q == 8'(STEPS - 1);
    fut     = dir_q ? (seg_q == 3'd0 ? 3'd5 : seg_q - 3'd1) : (seg_q == 3'd5 ? 3'd0 : seg_q + 3'd1);
    wrap    = step_w && (dir_q ? seg_q == 3'd0 : seg_q == 3'd5);
    tick_d  = tick_w ? '0 : tick_q + 1'b1;
    slot_d  = !tick_w ? slot_q : slot_w ? '0 : slot_q + 1'b1;
    frame_d = !slot_w ? frame_q : frame_w ? '0 : frame_q + 1'b1;
    step_d  = !frame_w ? step_q : step_w ? '0 : step_q + 1'b1;
    seg_d   = step_w ? fut : seg_q;
    dir_d   = step_w ? dir : dir_q;
`ifdef RAINBOW_FADER_BRIGHT_EN
    lit     = 32'(tick_q) * 32'd16 < (32'(bright) + 32'd1) * 32'(TICKS_PER_SLOT);
`else
    lit     = 1'b1;
`endif
    // future colour occupies the last `step` slots of each frame
    sel     = ({1'b0, slot_q} + {1'b0, step_q}) >= 9'(STEPS) ? fut : seg_q;
    led_d   = (lit ? COLORS[3 * sel +: 3] : 3'b000) ^ POL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q     <= '0;
      slot_q     <= '0;
      frame_q    <= '0;
      step_q     <= '0;
      seg_q      <= '0;
      dir_q      <= 1'b0;
      led        <= POL;
      frame_tick <= 1'b0;
      seg_done   <= 1'b0;
      cycle_done <= 1'b0;
    end else if (en) begin
      tick_q     <= tick_d;
      slot_q     <= slot_d;
      frame_q    <= frame_d;
      step_q     <= step_d;
      seg_q      <= seg_d;
      dir_q      <= dir_d;
      led        <= led_d;
      frame_tick <= slot_w;
      seg_done   <= step_w;
      cycle_done <= wrap;
    end else begin
      frame_tick <= 1'b0;
      seg_done   <= 1'b0;
      cycle_done <= 1'b0;
    end
  end
  assign seg_idx = seg_q;
endmodule

// File: tb/tb_rainbow_fader.sv
// tb_rainbow_fader: random stimulus against an arithmetic position model, scoreboard-checked every cycle
module tb_rainbow_fader;
  localparam int T = 2, S = 4, F = 2, AL = 1;
  localparam int L = T * S * F * S;
  logic       clk = 0, rst = 1, en = 0, dir = 0;
  logic [3:0] bright = 4'd15;
  logic [2:0] led, seg_idx;
  logic       frame_tick, seg_done, cycle_done;
  typedef struct {logic [2:0] led; logic [2:0] seg; logic ft, sd, cd;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int p = 0, mseg = 0, mdir = 0;
  logic [2:0] mled = 3'b111;
  rainbow_fader #(.TICKS_PER_SLOT(T), .STEPS(S), .FRAMES_PER_STEP(F), .ACTIVE_LOW(AL)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir),
`ifdef RAINBOW_FADER_BRIGHT_EN
    .bright(bright),
`endif
    .led(led), .seg_idx(seg_idx), .frame_tick(frame_tick), .seg_done(seg_done), .cycle_done(cycle_done));
  always #5 clk = ~clk;
  function automatic logic [2:0] colour(int i);
    case (i)
      0: return 3'b100;
      1: return 3'b101;
      2: return 3'b001;
      3: return 3'b011;
      4: return 3'b010;
      default: return 3'b110;
    endcase
  endfunction
  // p = enabled cycles elapsed within the current segment
  task automatic model_edge;
    exp_t e;
    e.ft = 0; e.sd = 0; e.cd = 0;
    if (rst) begin
      p = 0; mseg = 0; mdir = 0; mled = AL ? 3'b111 : 3'b000;
    end else if (en) begin
      int tick = p % T;
      int slot = (p / T) % S;
      int stp  = p / (T * S * F);
      int fut  = mdir ? (mseg + 5) % 6 : (mseg + 1) % 6;
      bit lit  = 1;
`ifdef RAINBOW_FADER_BRIGHT_EN
      lit = tick * 16 < (int'(bright) + 1) * T;
`endif
      mled = (lit ? colour(slot + stp >= S ? fut : mseg) : 3'b000) ^ (AL ? 3'b111 : 3'b000);
      e.ft = (p + 1) % (T * S) == 0;
      e.sd = p == L - 1;
      e.cd = e.sd && ((mdir == 0 && mseg == 5) || (mdir == 1 && mseg == 0));
      p++;
      if (p == L) begin p = 0; mseg = fut; mdir = int'(dir); end
    end
    e.led = mled; e.seg = 3'(mseg);
    q.push_back(e);
  endtask
  task automatic chk(string name, logic [2:0] act, logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("led", led, e.led);
      chk("seg_idx", seg_idx, e.seg);
      chk("frame_tick", {2'b0, frame_tick}, {2'b0, e.ft});
      chk("seg_done", {2'b0, seg_done}, {2'b0, e.sd});
      chk("cycle_done", {2'b0, cycle_done}, {2'b0, e.cd});
    end
  end
  initial begin
    for (int i = 0; i < 5000; i++) begin
      rst    = i < 3 || $urandom_range(0, 1499) == 0;
      en     = i < 3 ? 1'b1 : $urandom_range(0, 7) != 0;
      dir    = ((i / 1000) % 2 == 1) ^ ($urandom_range(0, 49) == 0);
      bright = i < 2500 ? 4'd15 : 4'($urandom_range(0, 15));
      model_edge;
      @(negedge clk);
    end
    @(posedge clk); #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
